cosim_trace_packer: RTL and testbench
=====================================

Name: cosim_trace_packer

Overview:
- Transmit-side producer of the two-lane commit-trace interface consumed by the cosim checker.
- Takes up to two commit records per cycle from a core's retire stage and buffers them in an in-order FIFO.
- Drains the FIFO onto registered trace_0/trace_1 lanes, together with a free-running cycle stamp and a constant hartid.
- Handles lane compaction, host-side pause and backpressure, and counts records it has to drop.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- HARTID, 0, value driven on hartid.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising clock edge resets all state.
- in_0_valid/in_1_valid  in  1  commit lane retired an instruction.
- in_0_iaddr/in_1_iaddr  in  64  instruction PC.
- in_0_insn/in_1_insn  in  32  instruction word.
- in_0_exception/in_1_exception  in  1  trap taken.
- in_0_interrupt/in_1_interrupt  in  1  interrupt taken.
- in_0_cause/in_1_cause  in  64  trap cause.
- in_0_has_wdata/in_1_has_wdata  in  1  register writeback present.
- in_0_wdata/in_1_wdata  in  64  writeback data.
- in_ready  out  1  packer can accept two records this cycle.
- out_pause  in  1  host holds the trace; no dequeue this cycle.
- cycle  out  64  cycle stamp of the current output beat.
- hartid  out  64  HARTID, zero-extended.
- trace_0_* / trace_1_*  out  valid 1, iaddr 64, insn 32, exception 1, interrupt 1, cause 64, has_wdata 1, wdata 64; emitted records.
- dropped_count  out  16  records lost while in_ready was low; saturating.

Behaviour:
- Record presence: lane i is present when in_i_valid | in_i_exception | in_i_interrupt.
- Enqueue condition: occurs when in_ready=1 and at least one lane is present.
  - Present records are written in lane order: lane0, then lane1.
  - If only lane1 is present, it occupies the next slot; no holes are left in the FIFO.
- in_ready: combinational, equal to (DEPTH - count) >= 2.
- Dropped records: any present record offered while in_ready=0 is discarded.
  - dropped_count adds the number of discarded records (1 or 2) and saturates at 0xFFFF.
- Dequeue: every edge where out_pause=0.
  - Pops n = min(count, 2) entries, oldest first, into the output registers.
  - The oldest entry goes to trace_0_*; the second, if present, goes to trace_1_*.
- Idle beat: if n=0, or out_pause=1, the output registers load all-zero lanes on that edge.
  - valid, exception, interrupt and cause must all be 0 so the consumer does not fire.
  - An output beat lasts exactly one cycle; records are never repeated.
- Paused FIFO: keeps its contents; no reordering occurs.
- Pass-through: every field is copied bit-exact from input to output.
  - An interrupt record with valid=0 is emitted with valid=0.
- Counters:
  - count_next = count + enq_n - n.
  - The pop uses pre-edge contents; enqueue and dequeue on the same edge are legal; there is no input-to-output bypass.
  - Minimum latency: a record sampled at edge E is visible on the trace lanes after edge E+1.
- Pointers: read and write pointers wrap modulo DEPTH.
  - A two-entry write or read may straddle the wrap point.
- Cycle stamp:
  - An internal 64-bit counter is 0 at reset and increments every cycle, wrapping at 2^64.
  - At each dequeue edge, cycle takes the counter's pre-edge value.
- Reset (reset=0 at an edge, including mid-drain or while paused):
  - FIFO emptied (count=0, pointers 0) and cycle counter=0.
  - dropped_count=0.
  - All trace output fields 0 and cycle output 0.
  - in_ready evaluates to 1 immediately after reset.
- hartid: constant HARTID at all times.

Test Plan:
- Hold reset=0 for 2 edges, then release with no inputs → all trace fields 0, in_ready=1; the internal counter reads 5 after 5 edges (check it on the next pop).
- Lane1-only record (iaddr 0x80000000, insn 0x00000013) at edge E → trace_0 carries it after E+1 with valid=1; trace_1_valid=0; the following beat is all-zero.
- DEPTH=8, out_pause=1, two records per cycle for 4 edges:
  - → count=8 and in_ready=0.
  - A fifth pair → dropped_count=2.
  - Drop pause → drains in order, 2 per beat, over 4 beats, then zero beats.
- Interrupt record (valid=0, interrupt=1, cause 0x8000000000000007) → emitted unchanged on trace_0 with valid=0.
- Steady 2 records/cycle with out_pause=0 for 100 cycles → dropped_count=0, in_ready stays 1, PCs emitted strictly in order across pointer wrap.
- reset=0 while count=6 → next beat all zero, dropped_count=0, count=0; a subsequent single record has its cycle stamp restart from 0.

Source files
------------

// File: rtl/cosim_trace_packer.sv
// Commit-trace producer: packs up to two retired records per cycle into an
// in-order FIFO and drains them onto two registered trace lanes.
module cosim_trace_packer #(
    parameter int unsigned DEPTH  = 8,
    parameter logic [63:0] HARTID = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_0_valid,
    input  logic [63:0] in_0_iaddr,
    input  logic [31:0] in_0_insn,
    input  logic        in_0_exception,
    input  logic        in_0_interrupt,
    input  logic [63:0] in_0_cause,
    input  logic        in_0_has_wdata,
    input  logic [63:0] in_0_wdata,
    input  logic        in_1_valid,
    input  logic [63:0] in_1_iaddr,
    input  logic [31:0] in_1_insn,
    input  logic        in_1_exception,
    input  logic        in_1_interrupt,
    input  logic [63:0] in_1_cause,
    input  logic        in_1_has_wdata,
    input  logic [63:0] in_1_wdata,
    output logic        in_ready,
    input  logic        out_pause,
    output logic [63:0] cycle,
    output logic [63:0] hartid,
    output logic        trace_0_valid,
    output logic [63:0] trace_0_iaddr,
    output logic [31:0] trace_0_insn,
    output logic        trace_0_exception,
    output logic        trace_0_interrupt,
    output logic [63:0] trace_0_cause,
    output logic        trace_0_has_wdata,
    output logic [63:0] trace_0_wdata,
    output logic        trace_1_valid,
    output logic [63:0] trace_1_iaddr,
    output logic [31:0] trace_1_insn,
    output logic        trace_1_exception,
    output logic        trace_1_interrupt,
    output logic [63:0] trace_1_cause,
    output logic        trace_1_has_wdata,
    output logic [63:0] trace_1_wdata,
    output logic [15:0] dropped_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - 2);

    typedef struct packed {
        logic        valid;
        logic [63:0] iaddr;
        logic [31:0] insn;
        logic        exception;
        logic        interrupt;
        logic [63:0] cause;
        logic        has_wdata;
        logic [63:0] wdata;
    } rec_t;

    rec_t          rec_0, rec_1, wr_a;
    rec_t          t0_q, t1_q;
    rec_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr, wptr_1, rptr_1;
    logic [CW-1:0] count;
    logic          pres_0, pres_1;
    logic [1:0]    offer_n, enq_n, pop_n, drop_n;
    logic [63:0]   stamp, cycle_q;
    logic [15:0]   dropped_q;
    logic [16:0]   drop_sum;

    assign rec_0 = '{valid: in_0_valid, iaddr: in_0_iaddr,
                     insn: in_0_insn, exception: in_0_exception,
                     interrupt: in_0_interrupt, cause: in_0_cause,
                     has_wdata: in_0_has_wdata, wdata: in_0_wdata};
    assign rec_1 = '{valid: in_1_valid, iaddr: in_1_iaddr,
                     insn: in_1_insn, exception: in_1_exception,
                     interrupt: in_1_interrupt, cause: in_1_cause,
                     has_wdata: in_1_has_wdata, wdata: in_1_wdata};

    assign pres_0   = in_0_valid | in_0_exception | in_0_interrupt;
    assign pres_1   = in_1_valid | in_1_exception | in_1_interrupt;
    assign in_ready = count <= MAX_FILL;
    assign wptr_1   = wptr + AW'(1);
    assign rptr_1   = rptr + AW'(1);
    assign drop_sum = {1'b0, dropped_q} + {15'd0, drop_n};

    // A lone lane-1 record takes the lane-0 write slot so no hole is left.
    always_comb begin
        offer_n = {1'b0, pres_0} + {1'b0, pres_1};
        enq_n   = 2'd0;
        drop_n  = 2'd0;
        pop_n   = 2'd0;
        wr_a    = pres_0 ? rec_0 : rec_1;
        if (in_ready) begin
            enq_n = offer_n;
        end else begin
            drop_n = offer_n;
        end
        if (!out_pause) begin
            if (count >= CW'(2)) begin
                pop_n = 2'd2;
            end else begin
                pop_n = count[1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            stamp     <= '0;
            cycle_q   <= '0;
            dropped_q <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
        end else begin
            stamp <= stamp + 64'd1;
            wptr  <= wptr + AW'(enq_n);
            rptr  <= rptr + AW'(pop_n);
            count <= count + CW'(enq_n) - CW'(pop_n);
            if (drop_n != 2'd0) begin
                dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            t0_q <= (pop_n != 2'd0) ? mem[rptr] : '0;
            t1_q <= (pop_n == 2'd2) ? mem[rptr_1] : '0;
            if (!out_pause) begin
                cycle_q <= stamp;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && enq_n != 2'd0) begin
            mem[wptr] <= wr_a;
        end
        if (reset && enq_n == 2'd2) begin
            mem[wptr_1] <= rec_1;
        end
    end

    assign cycle         = cycle_q;
    assign hartid        = HARTID;
    assign dropped_count = dropped_q;

    assign trace_0_valid     = t0_q.valid;
    assign trace_0_iaddr     = t0_q.iaddr;
    assign trace_0_insn      = t0_q.insn;
    assign trace_0_exception = t0_q.exception;
    assign trace_0_interrupt = t0_q.interrupt;
    assign trace_0_cause     = t0_q.cause;
    assign trace_0_has_wdata = t0_q.has_wdata;
    assign trace_0_wdata     = t0_q.wdata;
    assign trace_1_valid     = t1_q.valid;
    assign trace_1_iaddr     = t1_q.iaddr;
    assign trace_1_insn      = t1_q.insn;
    assign trace_1_exception = t1_q.exception;
    assign trace_1_interrupt = t1_q.interrupt;
    assign trace_1_cause     = t1_q.cause;
    assign trace_1_has_wdata = t1_q.has_wdata;
    assign trace_1_wdata     = t1_q.wdata;

endmodule

// File: tb/tb_cosim_trace_packer.sv
// Directed bench for cosim_trace_packer: compaction, fill/drop, drain order,
// interrupt pass-through, steady streaming across wrap, and mid-drain reset.
module tb_cosim_trace_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_0_valid, in_1_valid;
    logic [63:0] in_0_iaddr, in_1_iaddr;
    logic [31:0] in_0_insn, in_1_insn;
    logic        in_0_exception, in_1_exception;
    logic        in_0_interrupt, in_1_interrupt;
    logic [63:0] in_0_cause, in_1_cause;
    logic        in_0_has_wdata, in_1_has_wdata;
    logic [63:0] in_0_wdata, in_1_wdata;
    logic        in_ready;
    logic        out_pause;
    logic [63:0] cycle, hartid;
    logic        trace_0_valid, trace_1_valid;
    logic [63:0] trace_0_iaddr, trace_1_iaddr;
    logic [31:0] trace_0_insn, trace_1_insn;
    logic        trace_0_exception, trace_1_exception;
    logic        trace_0_interrupt, trace_1_interrupt;
    logic [63:0] trace_0_cause, trace_1_cause;
    logic        trace_0_has_wdata, trace_1_has_wdata;
    logic [63:0] trace_0_wdata, trace_1_wdata;
    logic [15:0] dropped_count;

    int n_chk  = 0;
    int n_pass = 0;
    int bad_ord, bad_rdy, got_n;
    logic [63:0] exp_pc, pc;

    cosim_trace_packer #(.DEPTH(8), .HARTID(64'd0)) dut (
        .clock(clock), .reset(reset),
        .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr),
        .in_0_insn(in_0_insn), .in_0_exception(in_0_exception),
        .in_0_interrupt(in_0_interrupt), .in_0_cause(in_0_cause),
        .in_0_has_wdata(in_0_has_wdata), .in_0_wdata(in_0_wdata),
        .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr),
        .in_1_insn(in_1_insn), .in_1_exception(in_1_exception),
        .in_1_interrupt(in_1_interrupt), .in_1_cause(in_1_cause),
        .in_1_has_wdata(in_1_has_wdata), .in_1_wdata(in_1_wdata),
        .in_ready(in_ready), .out_pause(out_pause),
        .cycle(cycle), .hartid(hartid),
        .trace_0_valid(trace_0_valid), .trace_0_iaddr(trace_0_iaddr),
        .trace_0_insn(trace_0_insn), .trace_0_exception(trace_0_exception),
        .trace_0_interrupt(trace_0_interrupt), .trace_0_cause(trace_0_cause),
        .trace_0_has_wdata(trace_0_has_wdata), .trace_0_wdata(trace_0_wdata),
        .trace_1_valid(trace_1_valid), .trace_1_iaddr(trace_1_iaddr),
        .trace_1_insn(trace_1_insn), .trace_1_exception(trace_1_exception),
        .trace_1_interrupt(trace_1_interrupt), .trace_1_cause(trace_1_cause),
        .trace_1_has_wdata(trace_1_has_wdata), .trace_1_wdata(trace_1_wdata),
        .dropped_count(dropped_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        in_0_valid = 0; in_0_iaddr = 0; in_0_insn = 0;
        in_0_exception = 0; in_0_interrupt = 0; in_0_cause = 0;
        in_0_has_wdata = 0; in_0_wdata = 0;
        in_1_valid = 0; in_1_iaddr = 0; in_1_insn = 0;
        in_1_exception = 0; in_1_interrupt = 0; in_1_cause = 0;
        in_1_has_wdata = 0; in_1_wdata = 0;
    endtask

    task automatic put0(input logic [63:0] a);
        in_0_valid = 1; in_0_iaddr = a; in_0_insn = a[31:0] ^ 32'h13;
        in_0_has_wdata = 1; in_0_wdata = ~a;
    endtask

    task automatic put1(input logic [63:0] a);
        in_1_valid = 1; in_1_iaddr = a; in_1_insn = a[31:0] ^ 32'h13;
        in_1_has_wdata = 1; in_1_wdata = ~a;
    endtask

    task automatic grab();
        if (trace_0_valid) begin
            if (trace_0_iaddr !== exp_pc) bad_ord++;
            exp_pc += 64'd4;
            got_n++;
        end
        if (trace_1_valid) begin
            if (trace_1_iaddr !== exp_pc) bad_ord++;
            exp_pc += 64'd4;
            got_n++;
        end
        if (!in_ready) bad_rdy++;
    endtask

    initial begin
        clr();
        out_pause = 0;
        reset = 0;
        tick();
        tick();
        reset = 1;
        chk("rst_t0_valid", 64'(trace_0_valid), 64'd0);
        chk("rst_t1_valid", 64'(trace_1_valid), 64'd0);
        chk("rst_cycle", cycle, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_hartid", hartid, 64'd0);
        chk("rst_dropped", 64'(dropped_count), 64'd0);

        // Lane1-only record; the pop shows the counter value 5.
        repeat (4) tick();
        in_1_valid = 1; in_1_iaddr = 64'h8000_0000; in_1_insn = 32'h13;
        tick();
        clr();
        chk("l1_no_bypass", 64'(trace_0_valid), 64'd0);
        chk("l1_cycle_pre", cycle, 64'd4);
        tick();
        chk("l1_t0_valid", 64'(trace_0_valid), 64'd1);
        chk("l1_t0_iaddr", trace_0_iaddr, 64'h8000_0000);
        chk("l1_t0_insn", 64'(trace_0_insn), 64'h13);
        chk("l1_t1_valid", 64'(trace_1_valid), 64'd0);
        chk("l1_cycle", cycle, 64'd5);
        tick();
        chk("l1_idle_valid", 64'(trace_0_valid), 64'd0);
        chk("l1_idle_iaddr", trace_0_iaddr, 64'd0);

        // Fill 8 entries while paused, then offer a fifth pair.
        out_pause = 1;
        for (int k = 0; k < 4; k++) begin
            put0(64'h1000 + 64'(8 * k));
            put1(64'h1004 + 64'(8 * k));
            tick();
        end
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_paused_idle", 64'(trace_0_valid), 64'd0);
        put0(64'h2222); put1(64'h2226);
        tick();
        clr();
        chk("fill_dropped", 64'(dropped_count), 64'd2);
        out_pause = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_t0_iaddr", trace_0_iaddr, 64'h1000 + 64'(8 * k));
            chk("drain_t1_iaddr", trace_1_iaddr, 64'h1004 + 64'(8 * k));
            chk("drain_valids",
                64'({trace_0_valid, trace_1_valid}), 64'd3);
        end
        chk("drain_t0_insn", 64'(trace_0_insn), 64'h1018 ^ 64'h13);
        chk("drain_t1_wdata", trace_1_wdata, ~64'h101C);
        tick();
        chk("drain_idle",
            64'({trace_0_valid, trace_1_valid}), 64'd0);
        chk("drain_ready", 64'(in_ready), 64'd1);

        // Reset with six entries queued.
        out_pause = 1;
        for (int k = 0; k < 3; k++) begin
            put0(64'h3000 + 64'(8 * k));
            put1(64'h3004 + 64'(8 * k));
            tick();
        end
        clr();
        out_pause = 0;
        reset = 0;
        tick();
        chk("mrst_t0_valid", 64'(trace_0_valid), 64'd0);
        chk("mrst_t0_iaddr", trace_0_iaddr, 64'd0);
        chk("mrst_dropped", 64'(dropped_count), 64'd2 - 64'd2);
        chk("mrst_cycle", cycle, 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        reset = 1;
        put0(64'h5000);
        tick();
        clr();
        chk("mrst_cycle_e", cycle, 64'd0);
        tick();
        chk("mrst_rec_iaddr", trace_0_iaddr, 64'h5000);
        chk("mrst_rec_cycle", cycle, 64'd1);
        tick();
        chk("mrst_empty", 64'(trace_0_valid), 64'd0);

        // Interrupt record without valid.
        in_0_interrupt = 1; in_0_iaddr = 64'h6000;
        in_0_cause = 64'h8000_0000_0000_0007;
        tick();
        clr();
        tick();
        chk("irq_valid", 64'(trace_0_valid), 64'd0);
        chk("irq_interrupt", 64'(trace_0_interrupt), 64'd1);
        chk("irq_cause", trace_0_cause, 64'h8000_0000_0000_0007);
        chk("irq_iaddr", trace_0_iaddr, 64'h6000);
        chk("irq_t1_valid", 64'(trace_1_valid), 64'd0);

        // Steady two records per cycle for 100 cycles.
        bad_ord = 0; bad_rdy = 0; got_n = 0;
        pc = 64'h4000; exp_pc = 64'h4000;
        for (int i = 0; i < 100; i++) begin
            put0(pc);
            put1(pc + 64'd4);
            pc += 64'd8;
            tick();
            grab();
        end
        clr();
        tick(); grab();
        tick(); grab();
        chk("steady_order", 64'(bad_ord), 64'd0);
        chk("steady_ready", 64'(bad_rdy), 64'd0);
        chk("steady_count", 64'(got_n), 64'd200);
        chk("steady_dropped", 64'(dropped_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
